// File: rtl/sram_arb_pkg.sv
// Shared types and default widths for the SRAM access arbiter, JTAG bridge and SRAM.
package sram_arb_pkg;

  localparam int unsigned SRAM_ADDR_W = 16;
  localparam int unsigned SRAM_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RD_WAIT = 2'd2,
    RESP    = 2'd3
  } state_t;

endpackage

// File: rtl/sram_access_arbiter_if.sv
// Requester-side bus of the SRAM access arbiter.
//   req_valid/req_we/req_addr/req_wdata : per-requester command (flattened, req i at slice i)
//   req_ready                           : one-hot accept pulse
//   rsp_valid/rsp_rdata                 : one-hot read-data valid pulse, shared read data
// master = requesters, slave = arbiter.
interface sram_access_arbiter_if
  import sram_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ADDR_W  = SRAM_ADDR_W,
  parameter int unsigned DATA_W  = SRAM_DATA_W
);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_we;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/sram_access_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requesting index at or above ptr,
// wrapping modulo N.
//   req : request vector
//   ptr : highest-priority index this cycle (must be < N)
//   gnt : one-hot grant
//   any : at least one request pending
module rr_arbiter #(
  parameter  int unsigned N     = 2,
  localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic             any
);

  // Walk offsets 0..N-1 from ptr; first requesting slot wins.
  always_comb begin
    int unsigned idx;
    logic        found;
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned off = 0; off < N; off++) begin
      idx = 32'(ptr) + off;
      if (idx >= N) idx = idx - N;
      for (int unsigned j = 0; j < N; j++) begin
        if (!found && req[j] && (j == idx)) begin
          gnt[j] = 1'b1;
          found  = 1'b1;
        end
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/sram_access_arbiter.sv
// Sole owner of the SRAM control bus: round-robin shares one single-port SRAM among
// NUM_REQ requesters, one access in flight, single-cycle enable strobes.
//   clk, aclr (async, active-low)
//   bus               : requester interface (slave side)
//   sram_address      : SRAM address, holds last value between accesses
//   sram_data_in      : SRAM write data, holds last value between accesses
//   sram_data_out     : SRAM read data, valid RD_LAT edges after read_enable is sampled
//   sram_write_enable : one-cycle write strobe
//   sram_read_enable  : one-cycle read strobe
//   busy              : state != IDLE
module sram_access_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = SRAM_ADDR_W,
  parameter int unsigned DATA_W  = SRAM_DATA_W,
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned RD_LAT  = 1
) (
  input  logic                clk,
  input  logic                aclr,
  sram_access_arbiter_if.slave bus,
  output logic [ADDR_W-1:0]   sram_address,
  output logic [DATA_W-1:0]   sram_data_in,
  input  logic [DATA_W-1:0]   sram_data_out,
  output logic                sram_write_enable,
  output logic                sram_read_enable,
  output logic                busy
);

  localparam int unsigned PTR_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W     = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam int unsigned WAIT_LAST = (RD_LAT > 1) ? RD_LAT - 2 : 0;

  state_t               state_q, state_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [NUM_REQ-1:0]   owner_q, owner_d;
  logic                 we_q, we_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0]    addr_d;
  logic [DATA_W-1:0]    wdata_d;
  logic                 wr_en_d, rd_en_d;
  logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]    rsp_rdata_q, rsp_rdata_d;
  logic [NUM_REQ-1:0]   req_ready_c;
  logic [NUM_REQ-1:0]   gnt;
  logic                 any;
  logic [PTR_W-1:0]     gnt_idx;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req (bus.req_valid),
    .ptr (ptr_q),
    .gnt (gnt),
    .any (any)
  );

  // One-hot grant to index, for the rotation pointer.
  always_comb begin
    gnt_idx = '0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (gnt[j]) gnt_idx = PTR_W'(j);
    end
  end

  // State register.
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; RD_WAIT is skipped when the SRAM answers in one edge.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (any) state_d = ACCESS;
      ACCESS:  state_d = we_q ? IDLE : ((RD_LAT == 1) ? RESP : RD_WAIT);
      RD_WAIT: if (cnt_q == CNT_W'(WAIT_LAST)) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output/datapath next values; strobes are loaded on entry to ACCESS so they
  // are registered and high for exactly that one cycle.
  always_comb begin
    req_ready_c = '0;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    we_d        = we_q;
    cnt_d       = cnt_q;
    addr_d      = sram_address;
    wdata_d     = sram_data_in;
    wr_en_d     = 1'b0;
    rd_en_d     = 1'b0;
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (any) begin
          req_ready_c = gnt;
          owner_d     = gnt;
          ptr_d       = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
          for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (gnt[j]) begin
              we_d    = bus.req_we[j];
              addr_d  = bus.req_addr[j*ADDR_W +: ADDR_W];
              wdata_d = bus.req_wdata[j*DATA_W +: DATA_W];
            end
          end
          wr_en_d = we_d;
          rd_en_d = ~we_d;
          cnt_d   = '0;
        end
      end
      RD_WAIT: cnt_d = cnt_q + CNT_W'(1);
      RESP: begin
        rsp_rdata_d = sram_data_out;
        rsp_valid_d = owner_q;
      end
      default: ;
    endcase
  end

  // Output and context registers.
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      ptr_q             <= '0;
      owner_q           <= '0;
      we_q              <= 1'b0;
      cnt_q             <= '0;
      sram_address      <= '0;
      sram_data_in      <= '0;
      sram_write_enable <= 1'b0;
      sram_read_enable  <= 1'b0;
      rsp_valid_q       <= '0;
      rsp_rdata_q       <= '0;
      busy              <= 1'b0;
    end else begin
      ptr_q             <= ptr_d;
      owner_q           <= owner_d;
      we_q              <= we_d;
      cnt_q             <= cnt_d;
      sram_address      <= addr_d;
      sram_data_in      <= wdata_d;
      sram_write_enable <= wr_en_d;
      sram_read_enable  <= rd_en_d;
      rsp_valid_q       <= rsp_valid_d;
      rsp_rdata_q       <= rsp_rdata_d;
      busy              <= (state_d != IDLE);
    end
  end

  assign bus.req_ready = req_ready_c;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Directed bench for sram_access_arbiter: dut_a uses RD_LAT=1, dut_b uses RD_LAT=3,
// each with its own behavioural SRAM.
module tb_sram_access_arbiter;

  logic clk;
  logic aclr;

  int vectors;
  int miscompares;

  logic [15:0] a_addr, b_addr;
  logic [7:0]  a_din, a_dout, b_din, b_dout;
  logic        a_we, a_re, a_busy, b_we, b_re, b_busy;

  sram_access_arbiter_if #(.NUM_REQ(2), .ADDR_W(16), .DATA_W(8)) bus_a ();
  sram_access_arbiter_if #(.NUM_REQ(2), .ADDR_W(16), .DATA_W(8)) bus_b ();

  sram_access_arbiter #(.ADDR_W(16), .DATA_W(8), .NUM_REQ(2), .RD_LAT(1)) dut_a (
    .clk               (clk),
    .aclr              (aclr),
    .bus               (bus_a),
    .sram_address      (a_addr),
    .sram_data_in      (a_din),
    .sram_data_out     (a_dout),
    .sram_write_enable (a_we),
    .sram_read_enable  (a_re),
    .busy              (a_busy)
  );

  sram_access_arbiter #(.ADDR_W(16), .DATA_W(8), .NUM_REQ(2), .RD_LAT(3)) dut_b (
    .clk               (clk),
    .aclr              (aclr),
    .bus               (bus_b),
    .sram_address      (b_addr),
    .sram_data_in      (b_din),
    .sram_data_out     (b_dout),
    .sram_write_enable (b_we),
    .sram_read_enable  (b_re),
    .busy              (b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural SRAMs; out-of-slot data is 0xEE so a mistimed capture shows up.
  logic [7:0] mem_a [0:65535];
  logic [7:0] mem_b [0:65535];
  logic [7:0] pipe_a;
  logic [7:0] pipe_b [0:2];

  always_ff @(posedge clk) begin
    if (a_we) mem_a[a_addr] <= a_din;
    pipe_a <= a_re ? mem_a[a_addr] : 8'hEE;
    if (b_we) mem_b[b_addr] <= b_din;
    pipe_b[0] <= b_re ? mem_b[b_addr] : 8'hEE;
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end

  assign a_dout = pipe_a;
  assign b_dout = pipe_b[2];

  task automatic apply_reset();
    aclr = 1'b0;
    bus_a.req_valid = '0;
    bus_b.req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    aclr = 1'b1;
    @(negedge clk);
  endtask

  // Present a request at the current negedge, wait (bounded) for ready, drop valid
  // at the negedge after acceptance.
  task automatic issue(input bit on_b, input int r, input bit we,
                       input logic [15:0] a, input logic [7:0] d, output bit ok);
    int t;
    if (on_b) begin
      bus_b.req_we[r] = we; bus_b.req_addr[r*16 +: 16] = a;
      bus_b.req_wdata[r*8 +: 8] = d; bus_b.req_valid[r] = 1'b1;
    end else begin
      bus_a.req_we[r] = we; bus_a.req_addr[r*16 +: 16] = a;
      bus_a.req_wdata[r*8 +: 8] = d; bus_a.req_valid[r] = 1'b1;
    end
    t = 0;
    #1;
    while (!(on_b ? bus_b.req_ready[r] : bus_a.req_ready[r]) && t < 20) begin
      @(negedge clk); #1; t++;
    end
    ok = on_b ? bus_b.req_ready[r] : bus_a.req_ready[r];
    @(negedge clk);
    if (on_b) bus_b.req_valid[r] = 1'b0;
    else      bus_a.req_valid[r] = 1'b0;
  endtask

  // Count cycles from acceptance to rsp_valid; called one cycle after acceptance.
  task automatic wait_rsp(input bit on_b, output int cyc,
                          output logic [1:0] vld, output logic [7:0] d);
    cyc = 1;
    while ((on_b ? bus_b.rsp_valid : bus_a.rsp_valid) == 2'b00 && cyc < 20) begin
      @(negedge clk); cyc++;
    end
    vld = on_b ? bus_b.rsp_valid : bus_a.rsp_valid;
    d   = on_b ? bus_b.rsp_rdata : bus_a.rsp_rdata;
  endtask

  task automatic test_reset();
    bit saw_bad;
    aclr = 1'b0;
    bus_a.req_valid = '0; bus_a.req_we = '0; bus_a.req_addr = '0; bus_a.req_wdata = '0;
    bus_b.req_valid = '0; bus_b.req_we = '0; bus_b.req_addr = '0; bus_b.req_wdata = '0;
    @(negedge clk); #1;
    vectors++;
    if ({a_we, a_re, a_busy, bus_a.req_ready, bus_a.rsp_valid, bus_a.rsp_rdata, a_addr, a_din} !== 39'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: we=%b re=%b busy=%b rdy=%b rsp=%b rd=%h addr=%h din=%h, expected all 0",
               a_we, a_re, a_busy, bus_a.req_ready, bus_a.rsp_valid, bus_a.rsp_rdata, a_addr, a_din);
    end
    @(negedge clk);
    aclr = 1'b1;
    @(negedge clk);
    bus_a.req_we[0] = 1'b0; bus_a.req_addr[15:0] = 16'h0010; bus_a.req_valid[0] = 1'b1;
    @(negedge clk);
    bus_a.req_valid[0] = 1'b0;
    #1;
    vectors++;
    if (a_re !== 1'b1) begin
      miscompares++; $display("FAIL reset_read_started: re=%b expected 1", a_re);
    end
    #2;
    aclr = 1'b0;
    #1;
    vectors++;
    if ({a_re, a_we, a_busy, bus_a.rsp_valid} !== 5'b00000) begin
      miscompares++;
      $display("FAIL reset_mid_read: re=%b we=%b busy=%b rsp=%b expected 0", a_re, a_we, a_busy, bus_a.rsp_valid);
    end
    @(negedge clk);
    aclr = 1'b1;
    saw_bad = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      if (bus_a.rsp_valid !== 2'b00 || a_busy !== 1'b0 || a_re !== 1'b0) saw_bad = 1'b1;
      @(negedge clk);
    end
    vectors++;
    if (saw_bad !== 1'b0) begin
      miscompares++; $display("FAIL reset_no_rsp: activity after release=%b expected 0", saw_bad);
    end
  endtask

  task automatic test_write_read();
    apply_reset();
    bus_a.req_we[0] = 1'b1; bus_a.req_addr[15:0] = 16'h0010;
    bus_a.req_wdata[7:0] = 8'hA5; bus_a.req_valid[0] = 1'b1;
    #1;
    vectors++;
    if (bus_a.req_ready !== 2'b01) begin
      miscompares++; $display("FAIL wr_ready: got %b expected 01", bus_a.req_ready);
    end
    @(negedge clk);
    bus_a.req_valid[0] = 1'b0;
    #1;
    vectors++;
    if ({a_we, a_re} !== 2'b10 || a_addr !== 16'h0010 || a_din !== 8'hA5 || a_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL wr_strobe: we=%b re=%b addr=%h din=%h busy=%b expected 1 0 0010 a5 1",
               a_we, a_re, a_addr, a_din, a_busy);
    end
    @(negedge clk); #1;
    vectors++;
    if ({a_we, a_re, a_busy} !== 3'b000 || a_addr !== 16'h0010) begin
      miscompares++;
      $display("FAIL wr_done: we=%b re=%b busy=%b addr=%h expected 0 0 0 0010", a_we, a_re, a_busy, a_addr);
    end
    bus_a.req_we[0] = 1'b0; bus_a.req_valid[0] = 1'b1;
    #1;
    vectors++;
    if (bus_a.req_ready !== 2'b01) begin
      miscompares++; $display("FAIL rd_ready: got %b expected 01", bus_a.req_ready);
    end
    @(negedge clk);
    bus_a.req_valid[0] = 1'b0;
    #1;
    vectors++;
    if ({a_we, a_re, bus_a.rsp_valid} !== 4'b0100) begin
      miscompares++; $display("FAIL rd_strobe: we=%b re=%b rsp=%b expected 0 1 00", a_we, a_re, bus_a.rsp_valid);
    end
    @(negedge clk); #1;
    vectors++;
    if ({a_re, bus_a.rsp_valid} !== 3'b000) begin
      miscompares++; $display("FAIL rd_resp_state: re=%b rsp=%b expected 0 00", a_re, bus_a.rsp_valid);
    end
    @(negedge clk); #1;
    vectors++;
    if (bus_a.rsp_valid !== 2'b01 || bus_a.rsp_rdata !== 8'hA5) begin
      miscompares++;
      $display("FAIL rd_data: rsp=%b data=%h expected 01 a5", bus_a.rsp_valid, bus_a.rsp_rdata);
    end
    @(negedge clk); #1;
    vectors++;
    if (bus_a.rsp_valid !== 2'b00 || bus_a.rsp_rdata !== 8'hA5) begin
      miscompares++;
      $display("FAIL rd_hold: rsp=%b data=%h expected 00 a5", bus_a.rsp_valid, bus_a.rsp_rdata);
    end
  endtask

  task automatic test_contention();
    // {req_ready[1:0], write_enable, read_enable, rsp_valid[1:0]} per cycle:
    // req0 writes, req1 reads, both held valid from reset.
    logic [5:0] exp [0:10];
    exp = '{6'b010000, 6'b001000, 6'b100000, 6'b000100, 6'b000000,
            6'b010010, 6'b001000, 6'b100000, 6'b000100, 6'b000000, 6'b010010};
    apply_reset();
    bus_a.req_we[0] = 1'b1; bus_a.req_addr[15:0]  = 16'h0100; bus_a.req_wdata[7:0]  = 8'h3C;
    bus_a.req_we[1] = 1'b0; bus_a.req_addr[31:16] = 16'h0010; bus_a.req_wdata[15:8] = 8'h00;
    bus_a.req_valid = 2'b11;
    for (int k = 0; k < 11; k++) begin
      #1;
      vectors++;
      if ({bus_a.req_ready, a_we, a_re, bus_a.rsp_valid} !== exp[k]) begin
        miscompares++;
        $display("FAIL contention_c%0d: rdy/we/re/rsp=%b expected %b", k,
                 {bus_a.req_ready, a_we, a_re, bus_a.rsp_valid}, exp[k]);
      end
      if (k == 5 || k == 10) begin
        vectors++;
        if (bus_a.rsp_rdata !== 8'hA5) begin
          miscompares++; $display("FAIL contention_data_c%0d: got %h expected a5", k, bus_a.rsp_rdata);
        end
      end
      if (k == 10) bus_a.req_valid = 2'b00;
      @(negedge clk);
    end
  endtask

  task automatic test_busy_hold();
    bit ok;
    apply_reset();
    issue(1'b1, 1, 1'b1, 16'h0020, 8'h5C, ok);
    vectors++;
    if (ok !== 1'b1) begin
      miscompares++; $display("FAIL busy_setup_write: ready=%b expected 1", ok);
    end
    @(negedge clk);
    bus_b.req_we[0] = 1'b0; bus_b.req_addr[15:0] = 16'h0020; bus_b.req_valid[0] = 1'b1;
    #1;
    vectors++;
    if (bus_b.req_ready !== 2'b01) begin
      miscompares++; $display("FAIL busy_rd0_ready: got %b expected 01", bus_b.req_ready);
    end
    @(negedge clk);
    bus_b.req_valid[0] = 1'b0;
    @(negedge clk);
    bus_b.req_we[1] = 1'b0; bus_b.req_addr[31:16] = 16'h0020; bus_b.req_valid[1] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      vectors++;
      if (bus_b.req_ready !== 2'b00 || b_busy !== 1'b1) begin
        miscompares++;
        $display("FAIL busy_hold_c%0d: rdy=%b busy=%b expected 00 1", k, bus_b.req_ready, b_busy);
      end
      @(negedge clk);
    end
    #1;
    vectors++;
    if (bus_b.req_ready !== 2'b10 || bus_b.rsp_valid !== 2'b01 || bus_b.rsp_rdata !== 8'h5C) begin
      miscompares++;
      $display("FAIL busy_release: rdy=%b rsp=%b data=%h expected 10 01 5c",
               bus_b.req_ready, bus_b.rsp_valid, bus_b.rsp_rdata);
    end
    @(negedge clk);
    bus_b.req_valid[1] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      vectors++;
      if (bus_b.rsp_valid !== 2'b00) begin
        miscompares++; $display("FAIL busy_rsp_quiet_c%0d: rsp=%b expected 00", k, bus_b.rsp_valid);
      end
      @(negedge clk);
    end
    #1;
    vectors++;
    if (bus_b.rsp_valid !== 2'b10 || bus_b.rsp_rdata !== 8'h5C) begin
      miscompares++;
      $display("FAIL busy_owner_rsp: rsp=%b data=%h expected 10 5c", bus_b.rsp_valid, bus_b.rsp_rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_boundaries();
    bit         ok;
    int         lat;
    logic [1:0] vld;
    logic [7:0] d;
    bit         saw_bad;

    issue(1'b0, 0, 1'b1, 16'hFFFF, 8'h00, ok);
    @(negedge clk);
    issue(1'b0, 0, 1'b0, 16'hFFFF, 8'h00, ok);
    wait_rsp(1'b0, lat, vld, d);
    vectors++;
    if (lat != 3 || vld !== 2'b01 || d !== 8'h00) begin
      miscompares++;
      $display("FAIL bound_ffff_00: lat=%0d rsp=%b data=%h expected 3 01 00", lat, vld, d);
    end

    issue(1'b0, 1, 1'b1, 16'hFFFF, 8'hFF, ok);
    @(negedge clk);
    issue(1'b0, 1, 1'b0, 16'hFFFF, 8'h00, ok);
    wait_rsp(1'b0, lat, vld, d);
    vectors++;
    if (lat != 3 || vld !== 2'b10 || d !== 8'hFF) begin
      miscompares++;
      $display("FAIL bound_ffff_ff: lat=%0d rsp=%b data=%h expected 3 10 ff", lat, vld, d);
    end

    issue(1'b1, 0, 1'b1, 16'h1234, 8'h96, ok);
    @(negedge clk);
    issue(1'b1, 0, 1'b0, 16'h1234, 8'h00, ok);
    wait_rsp(1'b1, lat, vld, d);
    vectors++;
    if (lat != 5 || vld !== 2'b01 || d !== 8'h96) begin
      miscompares++;
      $display("FAIL bound_rdlat3: lat=%0d rsp=%b data=%h expected 5 01 96", lat, vld, d);
    end

    @(negedge clk);
    issue(1'b0, 0, 1'b1, 16'h0040, 8'h11, ok);
    vectors++;
    if (ok !== 1'b1 || a_we !== 1'b1 || a_addr !== 16'h0040) begin
      miscompares++;
      $display("FAIL pulse_setup: ready=%b we=%b addr=%h expected 1 1 0040", ok, a_we, a_addr);
    end
    bus_a.req_we[1] = 1'b1; bus_a.req_addr[31:16] = 16'h0050;
    bus_a.req_wdata[15:8] = 8'h22; bus_a.req_valid[1] = 1'b1;
    @(negedge clk);
    bus_a.req_valid[1] = 1'b0;
    saw_bad = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      if ({a_we, a_re, a_busy} !== 3'b000 || bus_a.req_ready !== 2'b00) saw_bad = 1'b1;
      @(negedge clk);
    end
    vectors++;
    if (saw_bad !== 1'b0 || a_addr !== 16'h0040) begin
      miscompares++;
      $display("FAIL pulse_no_access: activity=%b addr=%h expected 0 0040", saw_bad, a_addr);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_write_read();
    test_contention();
    test_busy_hold();
    test_boundaries();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
